// File: rtl/clk_div_mc.sv
// Multi-channel integer clock divider. Ratio changes take effect only at period
// boundaries, and a shared sync pulse restarts the period of every running channel.
module clk_div_mc #(
  parameter int CH_NUM    = 4,
  parameter int RATIO_WID = 8
) (
  input  logic                          i_clk,
  input  logic                          rst_n,
  input  logic [CH_NUM*RATIO_WID-1:0]   ratio,
  input  logic [CH_NUM-1:0]             ld,
  input  logic [CH_NUM-1:0]             en,
  input  logic                          sync,
  output logic [CH_NUM-1:0]             o_clk,
  output logic [CH_NUM-1:0]             div_en,
  output logic [CH_NUM-1:0]             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  localparam logic [RATIO_WID-1:0] ZERO_W = {RATIO_WID{1'b0}};
  localparam logic [RATIO_WID-1:0] ONE_W  = RATIO_WID'(1'b1);

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    state_t                 state_r, state_s;
    logic [RATIO_WID-1:0]   s_r, r_r, cnt_r;
    logic [RATIO_WID-1:0]   s_s, r_s, cnt_s, fld_s, last_s;
    logic [RATIO_WID:0]     p_s, half_s;
    logic                   start_r, start_s;
    logic                   q_r, q_s;
    logic                   div_en_r, div_en_s;
    logic                   busy_r, busy_s;
    logic                   wrap_s, stop_done_s, run_s, byp_s;
    logic                   gate_l;

    // Next-state: FSM, ratio shadow/active update and period counter.
    // start_r marks the one-cycle lead-in between leaving IDLE and the first high phase.
    always_comb begin
      fld_s       = ratio[c*RATIO_WID +: RATIO_WID];
      s_s         = ld[c] ? fld_s : s_r;
      last_s      = r_r - ONE_W;
      wrap_s      = (cnt_r == last_s);
      stop_done_s = (state_r == ST_STOP) && wrap_s && !start_r && !sync;
      state_s     = state_r;
      r_s         = r_r;
      cnt_s       = cnt_r;
      start_s     = start_r;
      case (state_r)
        ST_IDLE: begin
          r_s   = s_s;
          cnt_s = ZERO_W;
          if (en[c]) begin
            state_s = ST_RUN;
            start_s = 1'b1;
          end else begin
            state_s = ST_IDLE;
            start_s = 1'b0;
          end
        end
        ST_RUN, ST_STOP: begin
          if (start_r || sync || wrap_s) begin
            r_s     = s_s;
            cnt_s   = ZERO_W;
            start_s = 1'b0;
          end else begin
            cnt_s   = cnt_r + ONE_W;
          end
          if (en[c]) begin
            state_s = ST_RUN;
          end else if (stop_done_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_STOP;
          end
        end
        default: begin
          state_s = ST_IDLE;
          cnt_s   = ZERO_W;
          start_s = 1'b0;
        end
      endcase

      // Output values for the coming cycle; ratio 0 means a 2^RATIO_WID period.
      p_s      = (r_s == ZERO_W) ? {1'b1, ZERO_W} : {1'b0, r_s};
      half_s   = p_s >> 1'b1;
      run_s    = (state_s != ST_IDLE) && !start_s;
      byp_s    = run_s && (r_s == ONE_W);
      q_s      = run_s && !byp_s && ({1'b0, cnt_s} < half_s);
      div_en_s = run_s && (cnt_s == (r_s - ONE_W));
      busy_s   = (state_s != ST_IDLE);
    end

    // Channel state and output registers.
    always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r  <= ST_IDLE;
        s_r      <= ONE_W;
        r_r      <= ONE_W;
        cnt_r    <= ZERO_W;
        start_r  <= 1'b0;
        q_r      <= 1'b0;
        div_en_r <= 1'b0;
        busy_r   <= 1'b0;
      end else begin
        state_r  <= state_s;
        s_r      <= s_s;
        r_r      <= r_s;
        cnt_r    <= cnt_s;
        start_r  <= start_s;
        q_r      <= q_s;
        div_en_r <= div_en_s;
        busy_r   <= busy_s;
      end
    end

    // Bypass clock gate: enable is transparent only while i_clk is low.
    always_latch begin
      if (!rst_n) begin
        gate_l <= 1'b0;
      end else if (!i_clk) begin
        gate_l <= byp_s;
      end
    end

    // q_r is held low in bypass, so the OR never merges two active sources.
    assign o_clk[c]  = q_r | (i_clk & gate_l);
    assign div_en[c] = div_en_r;
    assign busy[c]   = busy_r;
  end

endmodule
